// File: rtl/ps2_key_event_queue.sv
// -----------------------------------------------------------------------------
// ps2_key_event_queue
//
// Turns the PS/2 scan-code byte stream into 10-bit key events and queues them
// in a first-word-fall-through FIFO that the processor pops. It also keeps a
// live bitmap of which configured keys are held down.
//
// Event format: {release, ext, code[7:0]}
//   release = 1 for a break (F0-prefixed) code, 0 for a make code
//   ext     = 1 when the code was E0-prefixed
//
// Extra behaviour on top of plain decoding:
//   - A partial prefix (E0 / F0 / E0 F0) that waits TIMEOUT_CYCLES without a
//     further byte is abandoned, and the decoder returns to idle.
//   - Typematic repeat makes (the same make arriving again while the key is
//     still down) can be filtered out of the FIFO.
//   - A push into a full FIFO that is not matched by a pop sets a sticky
//     overflow flag.
//
// Parameters
//   DEPTH          FIFO entries, power of two, >= 2
//   ADDR_W         log2(DEPTH)
//   NKEYS          number of tracked held-key bits
//   KEY_CODES      10 bits per key, key i at [10i+9:10i]; bit 9 of a slot is
//                  the ext flag, bits 7:0 the scan code, bit 8 is not used
//   TIMEOUT_CYCLES cycles a partial prefix may wait, >= 2
//   REPEAT_FILTER  1 = drop typematic repeat makes, 0 = queue every make
//
// Ports
//   clock            in   system clock
//   resetn           in   asynchronous active-low reset
//   ps2_key_pressed  in   one-cycle strobe, ps2_key_data is valid
//   ps2_key_data     in   received scan-code byte
//   evt_pop          in   consume head event (ignored when empty)
//   ovf_clr          in   clear the overflow flag
//   evt_valid        out  FIFO non-empty
//   evt_data         out  head event, 0 when empty
//   evt_count        out  number of queued events, 0..DEPTH
//   held             out  held[i] = 1 while key KEY_CODES[i] is down
//   overflow         out  sticky: an event was dropped because FIFO was full
// -----------------------------------------------------------------------------
module ps2_key_event_queue #(
    parameter int unsigned         DEPTH          = 8,
    parameter int unsigned         ADDR_W         = 3,
    parameter int unsigned         NKEYS          = 4,
    parameter logic [10*NKEYS-1:0] KEY_CODES      = {10'h274, 10'h26B, 10'h272, 10'h275},
    parameter int unsigned         TIMEOUT_CYCLES = 1_000_000,
    parameter bit                  REPEAT_FILTER  = 1'b1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              ps2_key_pressed,
    input  logic [7:0]        ps2_key_data,
    input  logic              evt_pop,
    input  logic              ovf_clr,
    output logic              evt_valid,
    output logic [9:0]        evt_data,
    output logic [ADDR_W:0]   evt_count,
    output logic [NKEYS-1:0]  held,
    output logic              overflow
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int unsigned     TO_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXTBRK
    } state_e;

    // Keyboard self-test / ack / echo / resend responses. They are not key
    // codes and are discarded unless they arrive as the byte after F0.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFE);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q;

    logic [8:0]        last_make_q;
    logic              last_live_q;

    logic [NKEYS-1:0]  held_q, held_d;

    logic [9:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;

    // Decoded event for the current strobe (valid only on that cycle)
    logic              dec_vld;
    logic [9:0]        dec_evt;

    // -------------------------------------------------------------------------
    // Scan-code decoder: next state and event, combinational on the strobe so
    // the event lands in the FIFO at the following edge.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        dec_vld = 1'b0;
        dec_evt = {2'b00, ps2_key_data};

        if (ps2_key_pressed) begin
            unique case (state_q)
                S_IDLE: begin
                    if (ps2_key_data == BYTE_EXT) begin
                        state_d = S_EXT;
                    end else if (ps2_key_data == BYTE_BRK) begin
                        state_d = S_BRK;
                    end else if (!is_ctrl_byte(ps2_key_data)) begin
                        dec_vld = 1'b1;
                        dec_evt = {1'b0, 1'b0, ps2_key_data};
                    end
                end
                S_EXT: begin
                    if (ps2_key_data == BYTE_BRK) begin
                        state_d = S_EXTBRK;
                    end else if (ps2_key_data == BYTE_EXT) begin
                        state_d = S_EXT;
                    end else if (is_ctrl_byte(ps2_key_data)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_IDLE;
                        dec_vld = 1'b1;
                        dec_evt = {1'b0, 1'b1, ps2_key_data};
                    end
                end
                S_BRK: begin
                    if (ps2_key_data == BYTE_EXT) begin
                        state_d = S_EXT;     // new extended sequence restarts decoding
                    end else if (ps2_key_data == BYTE_BRK) begin
                        state_d = S_BRK;
                    end else begin
                        state_d = S_IDLE;
                        dec_vld = 1'b1;
                        dec_evt = {1'b1, 1'b0, ps2_key_data};
                    end
                end
                S_EXTBRK: begin
                    if (ps2_key_data == BYTE_EXT) begin
                        state_d = S_EXT;
                    end else if (ps2_key_data == BYTE_BRK) begin
                        state_d = S_EXTBRK;
                    end else begin
                        state_d = S_IDLE;
                        dec_vld = 1'b1;
                        dec_evt = {1'b1, 1'b1, ps2_key_data};
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && to_cnt_q == TO_LAST) begin
            // Prefix abandoned: the keyboard stopped mid-sequence.
            state_d = S_IDLE;
        end
    end

    // Decoder state and prefix timeout counter. The counter only runs while
    // a prefix is pending with no new byte.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of all others.
            state_q  <= S_IDLE;
            to_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (ps2_key_pressed || state_q == S_IDLE || to_cnt_q == TO_LAST) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Held-key bitmap: follows every decoded event, before the repeat filter
    // and regardless of FIFO space.
    // -------------------------------------------------------------------------
    always_comb begin
        held_d = held_q;
        if (dec_vld) begin
            for (int i = 0; i < NKEYS; i++) begin
                if (dec_evt[8]   == KEY_CODES[10*i+9] &&
                    dec_evt[7:0] == KEY_CODES[10*i +: 8]) begin
                    held_d[i] = ~dec_evt[9];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            held_q <= '0;
        end else begin
            held_q <= held_d;
        end
    end

    // -------------------------------------------------------------------------
    // Typematic repeat filter. last_make_q remembers the most recent queued
    // make; it stays armed (live) until the matching break arrives.
    // -------------------------------------------------------------------------
    logic repeat_hit;
    logic push;

    assign repeat_hit = REPEAT_FILTER && dec_vld && !dec_evt[9] &&
                        last_live_q && (dec_evt[8:0] == last_make_q);
    assign push       = dec_vld && !repeat_hit;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_make_q <= '0;
            last_live_q <= 1'b0;
        end else if (dec_vld && !dec_evt[9] && !repeat_hit) begin
            last_make_q <= dec_evt[8:0];
            last_live_q <= 1'b1;
        end else if (dec_vld && dec_evt[9] && dec_evt[8:0] == last_make_q) begin
            last_live_q <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // First-word-fall-through FIFO
    // -------------------------------------------------------------------------
    logic fifo_full;
    logic do_pop;
    logic do_push;
    logic drop;

    assign fifo_full = (count_q == FULL_CNT);
    assign do_pop    = evt_pop && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push   = push && (!fifo_full || do_pop);
    assign drop      = push && fifo_full && !do_pop;

    // NOTE: the storage array has no reset; only the pointers and count are
    // reset, and evt_data is masked to 0 while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= dec_evt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;   // DEPTH is a power of two: wraps naturally
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign evt_valid = (count_q != '0);
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : 10'h000;
    assign evt_count = count_q;
    assign held      = held_q;
    assign overflow  = overflow_q;

endmodule
